// File: rtl/upuart_rx_pkg.sv
// Shared definitions for the upuart receiver: FSM states and oversampling constants.
// Built with or without UPUART_RX_PARITY_EN; nothing here depends on it.
package upuart_defs;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    localparam int         OS_RATE     = 16;
    localparam logic [3:0] TICK_SAMP_A = 4'd7;
    localparam logic [3:0] TICK_SAMP_B = 4'd8;
    localparam logic [3:0] TICK_DECIDE = 4'd9;
    localparam logic [3:0] TICK_LAST   = 4'(OS_RATE - 1);

    // 2-of-3 majority vote over the mid-bit samples
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/upuart_rx_if.sv
// Receive-side word handshake between the UART receiver and its consumer.
// Master drives data/valid, slave drives ready.
interface upuart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );
endinterface

// File: rtl/upuart_rx_sync.sv
// Multi-flop synchroniser for an asynchronous input that idles high.
// Resets to all ones so a freshly reset line never looks like a start bit.
module upuart_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] chain;

    // shift the raw input through the flop chain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '1;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];
endmodule

// File: rtl/upuart_rx.sv
// UART receiver on a 16x oversample tick: start/data/[parity]/stop, LSB first.
// Define UPUART_RX_PARITY_EN to add par_en/par_odd/par_err and the PARITY state.
module upuart_rx
    import upuart_defs::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       os_tick,
    input  logic       rxd,
`ifdef UPUART_RX_PARITY_EN
    input  logic       par_en,
    input  logic       par_odd,
    output logic       par_err,
`endif
    upuart_rx_if.master rx,
    output logic       frm_err,
    output logic       ovr_err,
    output logic       busy
);
    localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

    logic                 rxd_s;
    state_t               state;
    logic [3:0]           tick_cnt;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 samp_a;
    logic                 samp_b;
    logic                 maj;
    logic                 at_mid;
    logic                 at_last;
`ifdef UPUART_RX_PARITY_EN
    logic                 par_bit;
    logic                 par_bad;
`endif

    upuart_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rxd_s)
    );

    assign maj     = majority3(samp_a, samp_b, rxd_s);
    assign at_mid  = (tick_cnt == TICK_DECIDE);
    assign at_last = (tick_cnt == TICK_LAST);
    assign busy    = (state != IDLE);
`ifdef UPUART_RX_PARITY_EN
    assign par_bad = (^shreg) ^ par_bit ^ par_odd;
`endif

    // frame FSM, bit sampling, shifter and output holding register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            samp_a      <= 1'b1;
            samp_b      <= 1'b1;
            rx.rx_data  <= '0;
            rx.rx_valid <= 1'b0;
            frm_err     <= 1'b0;
            ovr_err     <= 1'b0;
`ifdef UPUART_RX_PARITY_EN
            par_bit     <= 1'b0;
            par_err     <= 1'b0;
`endif
        end else begin
            frm_err <= 1'b0;
            ovr_err <= 1'b0;
`ifdef UPUART_RX_PARITY_EN
            par_err <= 1'b0;
`endif
            if (rx.rx_valid && rx.rx_ready) begin
                rx.rx_valid <= 1'b0;
            end

            if (!enable) begin
                state    <= IDLE;
                tick_cnt <= '0;
                bit_cnt  <= '0;
            end else if (os_tick) begin
                if (tick_cnt == TICK_SAMP_A) begin
                    samp_a <= rxd_s;
                end
                if (tick_cnt == TICK_SAMP_B) begin
                    samp_b <= rxd_s;
                end
                if (state != IDLE && state != BREAK) begin
                    tick_cnt <= at_last ? 4'd0 : tick_cnt + 4'd1;
                end

                unique case (state)
                    IDLE: begin
                        if (!rxd_s) begin
                            state    <= START;
                            tick_cnt <= '0;
                        end
                    end
                    START: begin
                        if (at_mid && maj) begin
                            state    <= IDLE;
                            tick_cnt <= '0;
                        end else if (at_last) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        if (at_mid) begin
                            shreg <= {maj, shreg[DATA_BITS-1:1]};
                        end
                        if (at_last) begin
                            if (bit_cnt == BIT_LAST) begin
                                bit_cnt <= '0;
`ifdef UPUART_RX_PARITY_EN
                                state   <= par_en ? PARITY : STOP;
`else
                                state   <= STOP;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end
                    PARITY: begin
`ifdef UPUART_RX_PARITY_EN
                        if (at_mid) begin
                            par_bit <= maj;
                        end
                        if (at_last) begin
                            state <= STOP;
                        end
`else
                        state <= IDLE;
`endif
                    end
                    STOP: begin
                        if (at_mid) begin
                            tick_cnt <= '0;
                            if (maj) begin
                                state <= IDLE;
                                if (rx.rx_valid && !rx.rx_ready) begin
                                    ovr_err <= 1'b1;
                                end else begin
                                    rx.rx_data  <= shreg;
                                    rx.rx_valid <= 1'b1;
`ifdef UPUART_RX_PARITY_EN
                                    par_err     <= par_en && par_bad;
`endif
                                end
                            end else begin
                                frm_err <= 1'b1;
                                state   <= BREAK;
                            end
                        end
                    end
                    BREAK: begin
                        if (rxd_s) begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        tick_cnt <= '0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_upuart_rx.sv
// Directed self-checking bench for upuart_rx, os_tick every 4 clk.
// Define UPUART_RX_PARITY_EN to also exercise the parity path.
module tb_upuart_rx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b1;
    logic rxd = 1'b1;
    logic os_tick;
    logic frm_err;
    logic ovr_err;
    logic busy;
    logic [1:0] div = 2'd0;
`ifdef UPUART_RX_PARITY_EN
    logic par_en = 1'b0;
    logic par_odd = 1'b0;
    logic par_err;
    int   par_cnt = 0;
`endif

    int checks = 0;
    int errors = 0;
    int valid_cnt = 0;
    int frm_cnt = 0;
    int ovr_cnt = 0;
    logic [7:0] last_data = 8'h00;
    logic prev_valid = 1'b0;

    upuart_rx_if #(.DATA_BITS(8)) bus();

    upuart_rx #(
        .DATA_BITS   (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .os_tick (os_tick),
        .rxd     (rxd),
`ifdef UPUART_RX_PARITY_EN
        .par_en  (par_en),
        .par_odd (par_odd),
        .par_err (par_err),
`endif
        .rx      (bus),
        .frm_err (frm_err),
        .ovr_err (ovr_err),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // 16x tick: one clk in four
    always @(posedge clk) div <= div + 2'd1;
    assign os_tick = (div == 2'd0);

    // event monitor: word arrivals and error pulses
    always @(negedge clk) begin
        prev_valid <= bus.rx_valid;
        if (bus.rx_valid && !prev_valid) begin
            valid_cnt <= valid_cnt + 1;
            last_data <= bus.rx_data;
        end
        if (frm_err) frm_cnt <= frm_cnt + 1;
        if (ovr_err) ovr_cnt <= ovr_cnt + 1;
`ifdef UPUART_RX_PARITY_EN
        if (par_err) par_cnt <= par_cnt + 1;
`endif
    end

    task automatic send_bit(input logic v);
        rxd = v;
        repeat (64) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_on,
                              input logic par_bit, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (par_on) send_bit(par_bit);
        send_bit(stop);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.rx_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b want 0", bus.rx_valid);
        end
        checks++;
        if (bus.rx_data !== 8'h00) begin
            errors++; $display("FAIL reset_data: got %h want 00", bus.rx_data);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b want 0", busy);
        end
        checks++;
        if (frm_err !== 1'b0) begin
            errors++; $display("FAIL reset_frm: got %b want 0", frm_err);
        end
        checks++;
        if (ovr_err !== 1'b0) begin
            errors++; $display("FAIL reset_ovr: got %b want 0", ovr_err);
        end
        rst = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_basic;
        int v0, f0, o0;
        bus.rx_ready = 1'b1;
        v0 = valid_cnt; f0 = frm_cnt; o0 = ovr_cnt;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        send_bit(1'b1);
        checks++;
        if (valid_cnt - v0 !== 1) begin
            errors++; $display("FAIL basic_count: got %0d want 1", valid_cnt - v0);
        end
        checks++;
        if (last_data !== 8'hA5) begin
            errors++; $display("FAIL basic_data: got %h want a5", last_data);
        end
        checks++;
        if (frm_cnt - f0 !== 0) begin
            errors++; $display("FAIL basic_frm: got %0d want 0", frm_cnt - f0);
        end
        checks++;
        if (ovr_cnt - o0 !== 0) begin
            errors++; $display("FAIL basic_ovr: got %0d want 0", ovr_cnt - o0);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL basic_idle: got %b want 0", busy);
        end
    endtask

    task automatic test_glitch;
        int v0, f0;
        v0 = valid_cnt; f0 = frm_cnt;
        rxd = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL glitch_busy: got %b want 1", busy);
        end
        rxd = 1'b1;
        repeat (192) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL glitch_idle: got %b want 0", busy);
        end
        checks++;
        if (valid_cnt - v0 !== 0) begin
            errors++; $display("FAIL glitch_valid: got %0d want 0", valid_cnt - v0);
        end
        checks++;
        if (frm_cnt - f0 !== 0) begin
            errors++; $display("FAIL glitch_frm: got %0d want 0", frm_cnt - f0);
        end
    endtask

    task automatic test_framing;
        int v0, f0;
        v0 = valid_cnt; f0 = frm_cnt;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        repeat (12 * 64) @(negedge clk);
        checks++;
        if (frm_cnt - f0 !== 1) begin
            errors++; $display("FAIL frm_pulse: got %0d want 1", frm_cnt - f0);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL frm_break: got %b want 1", busy);
        end
        rxd = 1'b1;
        repeat (128) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL frm_release: got %b want 0", busy);
        end
        checks++;
        if (valid_cnt - v0 !== 0) begin
            errors++; $display("FAIL frm_valid: got %0d want 0", valid_cnt - v0);
        end
        checks++;
        if (frm_cnt - f0 !== 1) begin
            errors++; $display("FAIL frm_single: got %0d want 1", frm_cnt - f0);
        end
    endtask

    task automatic test_overrun;
        int v0, o0;
        v0 = valid_cnt; o0 = ovr_cnt;
        bus.rx_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1);
        send_bit(1'b1);
        checks++;
        if (bus.rx_valid !== 1'b1) begin
            errors++; $display("FAIL ovr_valid: got %b want 1", bus.rx_valid);
        end
        checks++;
        if (bus.rx_data !== 8'h11) begin
            errors++; $display("FAIL ovr_data: got %h want 11", bus.rx_data);
        end
        checks++;
        if (ovr_cnt - o0 !== 1) begin
            errors++; $display("FAIL ovr_pulse: got %0d want 1", ovr_cnt - o0);
        end
        checks++;
        if (valid_cnt - v0 !== 1) begin
            errors++; $display("FAIL ovr_count: got %0d want 1", valid_cnt - v0);
        end
        bus.rx_ready = 1'b1;
        @(negedge clk);
        bus.rx_ready = 1'b0;
        checks++;
        if (bus.rx_valid !== 1'b0) begin
            errors++; $display("FAIL ovr_drain: got %b want 0", bus.rx_valid);
        end
        @(negedge clk);
        checks++;
        if (bus.rx_valid !== 1'b0) begin
            errors++; $display("FAIL ovr_drained: got %b want 0", bus.rx_valid);
        end
    endtask

    task automatic test_back_to_back;
        int v0, o0;
        bus.rx_ready = 1'b1;
        v0 = valid_cnt; o0 = ovr_cnt;
        send_frame(8'h81, 1'b0, 1'b0, 1'b1);
        checks++;
        if (last_data !== 8'h81) begin
            errors++; $display("FAIL b2b_first: got %h want 81", last_data);
        end
        send_frame(8'h7E, 1'b0, 1'b0, 1'b1);
        send_bit(1'b1);
        checks++;
        if (last_data !== 8'h7E) begin
            errors++; $display("FAIL b2b_second: got %h want 7e", last_data);
        end
        checks++;
        if (valid_cnt - v0 !== 2) begin
            errors++; $display("FAIL b2b_count: got %0d want 2", valid_cnt - v0);
        end
        checks++;
        if (ovr_cnt - o0 !== 0) begin
            errors++; $display("FAIL b2b_ovr: got %0d want 0", ovr_cnt - o0);
        end
    endtask

    task automatic test_rst_mid;
        int v0;
        bus.rx_ready = 1'b1;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rxd = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL rst_busy: got %b want 0", busy);
        end
        checks++;
        if (bus.rx_data !== 8'h00) begin
            errors++; $display("FAIL rst_data: got %h want 00", bus.rx_data);
        end
        checks++;
        if (bus.rx_valid !== 1'b0) begin
            errors++; $display("FAIL rst_valid: got %b want 0", bus.rx_valid);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        send_bit(1'b1);
        v0 = valid_cnt;
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        send_bit(1'b1);
        checks++;
        if (valid_cnt - v0 !== 1) begin
            errors++; $display("FAIL rst_count: got %0d want 1", valid_cnt - v0);
        end
        checks++;
        if (last_data !== 8'h5A) begin
            errors++; $display("FAIL rst_frame: got %h want 5a", last_data);
        end
    endtask

    task automatic test_enable;
        bus.rx_ready = 1'b0;
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL en_busy: got %b want 0", busy);
        end
        checks++;
        if (bus.rx_valid !== 1'b1) begin
            errors++; $display("FAIL en_valid: got %b want 1", bus.rx_valid);
        end
        checks++;
        if (bus.rx_data !== 8'hC3) begin
            errors++; $display("FAIL en_data: got %h want c3", bus.rx_data);
        end
        send_bit(1'b0);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL en_ignore: got %b want 0", busy);
        end
        rxd = 1'b1;
        enable = 1'b1;
        send_bit(1'b1);
        bus.rx_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.rx_valid !== 1'b0) begin
            errors++; $display("FAIL en_drain: got %b want 0", bus.rx_valid);
        end
        send_frame(8'h96, 1'b0, 1'b0, 1'b1);
        send_bit(1'b1);
        checks++;
        if (last_data !== 8'h96) begin
            errors++; $display("FAIL en_resync: got %h want 96", last_data);
        end
    endtask

`ifdef UPUART_RX_PARITY_EN
    task automatic test_parity;
        int p0;
        bus.rx_ready = 1'b1;
        par_en = 1'b1;
        par_odd = 1'b0;
        p0 = par_cnt;
        send_frame(8'h07, 1'b1, 1'b0, 1'b1);
        send_bit(1'b1);
        checks++;
        if (par_cnt - p0 !== 1) begin
            errors++; $display("FAIL par_bad: got %0d want 1", par_cnt - p0);
        end
        checks++;
        if (last_data !== 8'h07) begin
            errors++; $display("FAIL par_data: got %h want 07", last_data);
        end
        p0 = par_cnt;
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        send_bit(1'b1);
        checks++;
        if (par_cnt - p0 !== 0) begin
            errors++; $display("FAIL par_good: got %0d want 0", par_cnt - p0);
        end
        par_en = 1'b0;
    endtask
`endif

    initial begin
        bus.rx_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_glitch();
        test_framing();
        test_overrun();
        test_back_to_back();
        test_rst_mid();
        test_enable();
`ifdef UPUART_RX_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
